// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage load/store bundle between pipeline (master) and data memory (slave)
interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_mode;
    logic [1:0]  mem_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;

    modport master (
        output mem_read, mem_write, mem_mode, mem_ext, addr, wdata,
        input  rdata, stall, misalign
    );

    modport slave (
        input  mem_read, mem_write, mem_mode, mem_ext, addr, wdata,
        output rdata, stall, misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM serving byte/half/word loads and stores with fixed wait latency
// Optional access/stall counters are built in when DMEM_STATS_EN is defined.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]      stat_reads,
    output logic [31:0]      stat_writes,
    output logic [31:0]      stat_stalls
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_mode;
    logic [1:0]  r_ext;
    logic        r_write;
    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [1:0]  w_mode;
    logic        w_req;
    logic        w_misal;
    logic        w_start;
    logic        w_last;
    logic [31:0] w_word;
    logic [31:0] w_merged;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;
    logic        w_unused;

    // Mode 00 behaves exactly like a word access, so it is normalised before capture.
    assign w_mode   = (bus.mem_mode == 2'b00) ? 2'b11 : bus.mem_mode;
    assign w_req    = bus.mem_read | bus.mem_write;
    assign w_misal  = ((w_mode == 2'b10) && bus.addr[0]) ||
                      ((w_mode == 2'b11) && (bus.addr[1:0] != 2'b00));
    assign w_start  = (r_state == S_IDLE) && w_req && !w_misal;
    assign w_last   = (r_state == S_BUSY) && (r_cnt == 4'd0);

    assign bus.stall    = !rst && (w_start || (r_state == S_BUSY));
    assign bus.misalign = !rst && (r_state == S_IDLE) && w_req && w_misal;
    assign bus.rdata    = r_rdata;

    assign w_unused = &{1'b0, bus.addr[31:DEPTH_LOG2+2]};

    assign w_word = r_mem[r_addr[DEPTH_LOG2+1:2]];
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = w_word[{r_addr[1], 4'b0000} +: 16];
    assign w_sign = (r_ext == 2'b11);

    always_comb begin
        w_merged = w_word;
        case (r_mode)
            2'b01:   w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b10:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        case (r_mode)
            2'b01:   w_load = {{24{w_sign & w_byte[7]}}, w_byte};
            2'b10:   w_load = {{16{w_sign & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_mode  <= 2'b11;
            r_ext   <= 2'b00;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_mode  <= w_mode;
                        r_ext   <= bus.mem_ext;
                        r_write <= bus.mem_write;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_write) r_rdata <= w_load;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM is deliberately not reset; a reset aborts any pending write via r_state.
    always_ff @(posedge clk) begin
        if (!rst && w_last && r_write) r_mem[r_addr[DEPTH_LOG2+1:2]] <= w_merged;
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads  <= 32'd0;
            stat_writes <= 32'd0;
            stat_stalls <= 32'd0;
        end else begin
            if (w_last && !r_write) stat_reads  <= stat_reads + 32'd1;
            if (w_last && r_write)  stat_writes <= stat_writes + 32'd1;
            if (bus.stall)          stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a behavioural memory model
module tb_dmem_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    dmem_responder_if bus ();
`ifdef DMEM_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_stalls;
`endif

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [0:1023];
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] m,
                                               input logic [1:0] e, input logic [31:0] a);
        logic [31:0] v;
        if (m == 2'b01) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (e == 2'b11 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (m == 2'b10) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (e == 2'b11 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] m,
                                                input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        if (m == 2'b01)      mask = 32'hFF << (8 * a[1:0]);
        else if (m == 2'b10) mask = 32'hFFFF << (16 * a[1]);
        else                 mask = 32'hFFFF_FFFF;
        return (w & ~mask) | ((d << (m == 2'b01 ? 8 * a[1:0] : (m == 2'b10 ? 16 * a[1] : 0))) & mask);
    endfunction

    task automatic idle_inputs();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_mode = 2'($urandom); bus.mem_ext = 2'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;
    endtask

    // Starts at posedge+1 in IDLE, returns at posedge+1 back in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [1:0] mode, input logic [1:0] ext,
                          input logic [31:0] a, input logic [31:0] wd, input string nm);
        logic [1:0] m;
        logic mis;
        int n;
        m   = (mode == 2'b00) ? 2'b11 : mode;
        mis = (m == 2'b10 && a[0]) || (m == 2'b11 && a[1:0] != 2'b00);
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_mode = mode; bus.mem_ext = ext;
        bus.addr = a; bus.wdata = wd;
        @(negedge clk);
        if (mis) begin
            total++;
            if (bus.misalign !== 1'b1 || bus.stall !== 1'b0) begin
                bad++; $display("FAIL %s misalign_req: misalign=%b stall=%b want 1/0", nm, bus.misalign, bus.stall);
            end
            @(posedge clk); #1; idle_inputs();
            @(negedge clk);
            total++;
            if (bus.misalign !== 1'b0 || bus.stall !== 1'b0 || bus.rdata !== m_rdata) begin
                bad++; $display("FAIL %s misalign_after: misalign=%b stall=%b rdata=%h want 0/0/%h",
                                nm, bus.misalign, bus.stall, bus.rdata, m_rdata);
            end
            @(posedge clk); #1;
            return;
        end
        n = 0;
        while (bus.stall === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1; idle_inputs();
            @(negedge clk);
        end
        if (wr)      m_mem[a[11:2]] = model_store(m_mem[a[11:2]], m, a, wd);
        else if (rd) m_rdata = model_load(m_mem[a[11:2]], m, ext, a);
        total++;
        if (n != LAT + 1) begin
            bad++; $display("FAIL %s stall_len: got %0d want %0d", nm, n, LAT + 1);
        end
        total++;
        if (bus.rdata !== m_rdata || bus.misalign !== 1'b0) begin
            bad++; $display("FAIL %s done_rdata: rdata=%h misalign=%b want %h/0", nm, bus.rdata, bus.misalign, m_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_mode = 2'b11; bus.mem_ext = 2'b00;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.stall !== 1'b0 || bus.misalign !== 1'b0 || bus.rdata !== 32'h0) begin
            bad++; $display("FAIL reset_state: stall=%b misalign=%b rdata=%h want 0/0/0", bus.stall, bus.misalign, bus.rdata);
        end
        bus.addr = 32'h2;
        #1;
        total++;
        if (bus.misalign !== 1'b0 || bus.stall !== 1'b0) begin
            bad++; $display("FAIL reset_misalign: misalign=%b stall=%b want 0/0", bus.misalign, bus.stall);
        end
        idle_inputs();
        m_rdata = 32'h0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        access(0, 1, 2'b11, 2'b00, 32'h10, 32'hDEADBEEF, "sw_10");
        access(1, 0, 2'b11, 2'b00, 32'h10, 32'h0, "lw_10");
        total++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_10_const: rdata=%h want deadbeef", bus.rdata);
        end
    endtask

    task automatic test_subword();
        access(1, 0, 2'b01, 2'b11, 32'h13, 32'h0, "lb_13");
        total++;
        if (bus.rdata !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb_13_const: rdata=%h want ffffffde", bus.rdata); end
        access(1, 0, 2'b01, 2'b00, 32'h13, 32'h0, "lbu_13");
        total++;
        if (bus.rdata !== 32'h000000DE) begin bad++; $display("FAIL lbu_13_const: rdata=%h want 000000de", bus.rdata); end
        access(1, 0, 2'b10, 2'b11, 32'h10, 32'h0, "lh_10");
        total++;
        if (bus.rdata !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh_10_const: rdata=%h want ffffbeef", bus.rdata); end
    endtask

    task automatic test_store_lanes();
        access(0, 1, 2'b01, 2'b00, 32'h11, 32'h00000055, "sb_11");
        total++;
        if (bus.rdata !== 32'hFFFFBEEF) begin bad++; $display("FAIL sb_keeps_rdata: rdata=%h want ffffbeef", bus.rdata); end
        access(1, 0, 2'b11, 2'b00, 32'h10, 32'h0, "lw_after_sb");
        total++;
        if (bus.rdata !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_lanes_const: rdata=%h want dead55ef", bus.rdata); end
        access(0, 1, 2'b10, 2'b00, 32'h12, 32'h00001234, "sh_12");
        access(1, 0, 2'b00, 2'b00, 32'h10, 32'h0, "lw_mode00_after_sh");
        total++;
        if (bus.rdata !== 32'h123455EF) begin bad++; $display("FAIL sh_lanes_const: rdata=%h want 123455ef", bus.rdata); end
    endtask

    task automatic test_misalign();
        access(1, 0, 2'b11, 2'b00, 32'h12, 32'h0, "lw_12_mis");
        access(1, 0, 2'b10, 2'b11, 32'h11, 32'h0, "lh_11_mis");
        access(0, 1, 2'b11, 2'b00, 32'h11, 32'hFFFFFFFF, "sw_11_mis");
        access(1, 0, 2'b11, 2'b00, 32'h10, 32'h0, "lw_after_mis");
    endtask

    task automatic test_reset_mid_op();
        access(0, 1, 2'b11, 2'b00, 32'h20, 32'h11223344, "sw_20_init");
        access(1, 0, 2'b11, 2'b00, 32'h10, 32'h0, "lw_10_nonzero");
        bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.mem_mode = 2'b11; bus.mem_ext = 2'b00;
        bus.addr = 32'h20; bus.wdata = 32'hAAAAAAAA;
        @(posedge clk); #1; idle_inputs();
        rst = 1'b1;
        #1;
        total++;
        if (bus.stall !== 1'b0 || bus.rdata !== 32'h0) begin
            bad++; $display("FAIL rst_mid_op: stall=%b rdata=%h want 0/0", bus.stall, bus.rdata);
        end
        m_rdata = 32'h0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        access(1, 0, 2'b11, 2'b00, 32'h20, 32'h0, "lw_20_after_rst");
        total++;
        if (bus.rdata === 32'hAAAAAAAA) begin bad++; $display("FAIL rst_discard_write: rdata=%h must not be aaaaaaaa", bus.rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            access(0, 1, 2'b11, 2'b00, 32'h100 + 4 * i, $urandom, "rnd_init");
        for (int i = 0; i < 60; i++) begin
            logic rd, wr;
            logic [31:0] a;
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            a = {4'($urandom), 28'h100 + 28'($urandom_range(0, 63))};
            access(rd, wr, 2'($urandom), 2'($urandom), a, $urandom, "rnd_op");
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        logic [31:0] r0, w0, s0;
        r0 = stat_reads; w0 = stat_writes; s0 = stat_stalls;
        access(0, 1, 2'b11, 2'b00, 32'h40, 32'h01020304, "st_sw1");
        access(0, 1, 2'b01, 2'b00, 32'h41, 32'h000000AB, "st_sb2");
        access(1, 0, 2'b11, 2'b00, 32'h40, 32'h0, "st_lw1");
        access(1, 0, 2'b10, 2'b11, 32'h42, 32'h0, "st_lh2");
        access(1, 0, 2'b01, 2'b00, 32'h41, 32'h0, "st_lb3");
        access(1, 0, 2'b11, 2'b00, 32'h41, 32'h0, "st_mis");
        total++;
        if (stat_writes - w0 !== 32'd2 || stat_reads - r0 !== 32'd3 || stat_stalls - s0 !== 32'd15) begin
            bad++; $display("FAIL stats: writes=%0d reads=%0d stalls=%0d want 2/3/15",
                            stat_writes - w0, stat_reads - r0, stat_stalls - s0);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        m_rdata = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_store_lanes();
        test_misalign();
        test_reset_mid_op();
        test_random();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
